// File: rtl/dmem_responder.sv
// Slow data-memory responder for the MA stage: one read or write per request, optional error.
// Latency: WAIT_CYCLES+1 stall cycles after the request is seen, then a one-cycle ack.
// Backpressure: stall holds the whole pipeline; the request must stay stable until ack.
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        stall,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic            cap_wr, cap_bad;
    logic [AW-1:0]   cap_idx;
    logic [31:0]     cap_wdata;
    logic [31:0]     mem [DEPTH];

    logic            req, req_bad;
    logic            commit, com_wr, com_bad;
    logic [AW-1:0]   com_idx;
    logic [31:0]     com_wdata;

    assign req     = mem_rd | mem_wr;
    assign req_bad = (addr[1:0] != 2'b00) | (|addr[31:AW+2]) | (mem_rd & mem_wr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Commit happens on the edge that enters DONE; with no wait states the
    // captured registers are not loaded yet, so the live inputs are used.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        com_wr    = cap_wr;
        com_bad   = cap_bad;
        com_idx   = cap_idx;
        com_wdata = cap_wdata;
        stall     = 1'b0;
        ack       = 1'b0;
        err       = 1'b0;
        unique case (state)
            IDLE: begin
                stall = req;
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = DONE;
                        commit    = 1'b1;
                        com_wr    = mem_wr;
                        com_bad   = req_bad;
                        com_idx   = addr[AW+1:2];
                        com_wdata = wdata;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                ack       = 1'b1;
                err       = cap_bad;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_wr    <= 1'b0;
            cap_bad   <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= 32'd0;
            rdata     <= 32'd0;
        end else begin
            if (state == IDLE && req) begin
                cap_wr    <= mem_wr;
                cap_bad   <= req_bad;
                cap_idx   <= addr[AW+1:2];
                cap_wdata <= wdata;
            end
            if (commit && (com_bad || !com_wr))
                rdata <= com_bad ? 32'd0 : mem[com_idx];
        end
    end

    // Array is never cleared; reset only suppresses a pending write.
    always_ff @(posedge clk) begin
        if (commit && com_wr && !com_bad && !reset)
            mem[com_idx] <= com_wdata;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) against a transaction-level model.
// Directed accesses with literal expectations, plus per-cycle comparison of all outputs.
module tb_dmem_responder;
    logic        clk;
    logic        rst;
    logic        mem_rd [2];
    logic        mem_wr [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic [31:0] rdata  [2];
    logic        ack    [2];
    logic        stall  [2];
    logic        err    [2];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int wc [2] = '{2, 0};

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .reset(rst), .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]),
        .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]),
        .stall(stall[0]), .err(err[0]));

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(rst), .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]),
        .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]),
        .stall(stall[1]), .err(err[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: a request seen while idle occupies the next wc+1 cycles (stall),
    // then one ack cycle where its effect on memory/rdata becomes visible.
    int          ack_at [2] = '{-1, -1};
    logic        p_bad  [2];
    logic        p_wr   [2];
    int          p_idx  [2];
    logic [31:0] p_wd   [2];
    logic [31:0] m_rdata[2];
    logic [31:0] mmem   [2][256];
    logic        m_req, e_stall, e_ack, e_err;
    logic [31:0] m_addr;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_req   = mem_rd[i] | mem_wr[i];
            e_stall = 1'b0;
            e_ack   = 1'b0;
            e_err   = 1'b0;
            if (rst) begin
                ack_at[i]  = -1;
                m_rdata[i] = 32'd0;
                e_stall    = m_req;
            end else if (ack_at[i] == cyc) begin
                e_ack = 1'b1;
                e_err = p_bad[i];
                if (p_bad[i])     m_rdata[i] = 32'd0;
                else if (p_wr[i]) mmem[i][p_idx[i]] = p_wd[i];
                else              m_rdata[i] = mmem[i][p_idx[i]];
                ack_at[i] = -1;
            end else if (ack_at[i] > cyc) begin
                e_stall = 1'b1;
            end else begin
                e_stall = m_req;
                if (m_req) begin
                    m_addr    = addr[i];
                    p_bad[i]  = (m_addr % 4 != 0) || (m_addr >= 32'd1024) || (mem_rd[i] && mem_wr[i]);
                    p_wr[i]   = mem_wr[i];
                    p_idx[i]  = int'(m_addr / 4) % 256;
                    p_wd[i]   = wdata[i];
                    ack_at[i] = cyc + wc[i] + 1;
                end
            end
            chk($sformatf("stall%0d", i), {31'd0, stall[i]}, {31'd0, e_stall});
            chk($sformatf("ack%0d", i),   {31'd0, ack[i]},   {31'd0, e_ack});
            chk($sformatf("err%0d", i),   {31'd0, err[i]},   {31'd0, e_err});
            chk($sformatf("rdata%0d", i), rdata[i], m_rdata[i]);
        end
    end

    task automatic do_op(input int i, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, output int n_stall, output logic [31:0] rdat,
                         output logic e, output int ack_cyc);
        bit got = 0;
        @(posedge clk); #1;
        mem_rd[i] = rd; mem_wr[i] = wr; addr[i] = a; wdata[i] = d;
        n_stall = 0; rdat = 32'hx; e = 1'bx; ack_cyc = -1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (ack[i] === 1'b1) begin
                got = 1; rdat = rdata[i]; e = err[i]; ack_cyc = cyc;
            end else if (stall[i] === 1'b1) n_stall++;
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            mem_rd[i] = 0; mem_wr[i] = 0; addr[i] = 0; wdata[i] = 0;
        end
        repeat (n - 1) @(posedge clk);
    endtask

    initial begin
        int          ns, ac1, ac2, acks;
        logic [31:0] rd;
        logic        e;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mem_rd[i] = 0; mem_wr[i] = 0; addr[i] = 0; wdata[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rdata", rdata[0], 32'd0);
        chk("reset_ack", {31'd0, ack[0]}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: write with 2 wait states
        do_op(0, 0, 1, 32'h14, 32'hDEADBEEF, ns, rd, e, ac1);
        chk("wr_stall_cycles", ns, 3);
        chk("wr_err", {31'd0, e}, 32'd0);
        idle(2);
        // 2: read back, rdata holds after ack
        do_op(0, 1, 0, 32'h14, 32'd0, ns, rd, e, ac1);
        chk("rd_stall_cycles", ns, 3);
        chk("rd_data", rd, 32'hDEADBEEF);
        idle(3);
        chk("rd_hold", rdata[0], 32'hDEADBEEF);
        // 3: misaligned / out of range
        do_op(0, 1, 0, 32'h16, 32'd0, ns, rd, e, ac1);
        chk("misalign_err", {31'd0, e}, 32'd1);
        chk("misalign_rdata", rd, 32'd0);
        idle(1);
        do_op(0, 1, 0, 32'h400, 32'd0, ns, rd, e, ac1);
        chk("range_err", {31'd0, e}, 32'd1);
        idle(1);
        do_op(0, 0, 1, 32'h16, 32'h11111111, ns, rd, e, ac1);
        chk("misalign_wr_err", {31'd0, e}, 32'd1);
        idle(1);
        do_op(0, 0, 1, 32'h414, 32'h22222222, ns, rd, e, ac1);
        idle(1);
        do_op(0, 1, 0, 32'h14, 32'd0, ns, rd, e, ac1);
        chk("mem_unchanged", rd, 32'hDEADBEEF);
        idle(1);

        // 4: zero wait states, rd&wr conflict
        do_op(1, 0, 1, 32'h8, 32'hCAFE0002, ns, rd, e, ac1);
        chk("w0_stall_cycles", ns, 1);
        idle(1);
        do_op(1, 1, 1, 32'h8, 32'h00000BAD, ns, rd, e, ac1);
        chk("both_err", {31'd0, e}, 32'd1);
        chk("both_stall", ns, 1);
        idle(1);
        do_op(1, 1, 0, 32'h8, 32'd0, ns, rd, e, ac1);
        chk("both_mem_unchanged", rd, 32'hCAFE0002);
        idle(1);

        // 5: reset during WAIT aborts the write
        do_op(0, 0, 1, 32'h20, 32'h00000055, ns, rd, e, ac1);
        idle(1);
        @(posedge clk); #1;
        mem_wr[0] = 1; addr[0] = 32'h20; wdata[0] = 32'h1234;
        @(posedge clk); #1;
        rst = 1'b1; mem_wr[0] = 0;
        @(negedge clk);
        chk("rst_stall", {31'd0, stall[0]}, 32'd0);
        acks = 0;
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ack[0]) acks++;
        end
        chk("rst_no_ack", acks, 0);
        do_op(0, 1, 0, 32'h20, 32'd0, ns, rd, e, ac1);
        chk("rst_mem_unchanged", rd, 32'h00000055);
        idle(1);

        // 6: back-to-back write then read
        do_op(0, 0, 1, 32'h0, 32'hA, ns, rd, e, ac1);
        do_op(0, 1, 0, 32'h0, 32'd0, ns, rd, e, ac2);
        chk("b2b_data", rd, 32'hA);
        chk("b2b_gap", ac2 - ac1, 4);
        idle(1);
        do_op(1, 0, 1, 32'h4, 32'h77, ns, rd, e, ac1);
        do_op(1, 1, 0, 32'h4, 32'd0, ns, rd, e, ac2);
        chk("b2b_w0_data", rd, 32'h77);
        chk("b2b_w0_gap", ac2 - ac1, 2);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
